// File: rtl/walk_checker.sv
// Receive-side checker for a walking-ones pattern: syncs on the first 1, then
// expects each later valid beat to be the previous one shifted left up to the MSB.
module walk_checker #(
  parameter int WIDTH      = 8,
  parameter int SEEK_LIMIT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic [WIDTH-1:0] o_expected,
  output logic             o_mismatch,
  output logic [7:0]       o_err_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEEK  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LP_ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] LP_MSB        = LP_ONE << (WIDTH - 1);
  localparam logic [7:0]       LP_SEEK_LIMIT = 8'(SEEK_LIMIT);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_expected, w_expected_nxt;
  logic             r_mismatch, w_mismatch_nxt;
  logic [7:0]       r_err_count, w_err_nxt;
  logic [7:0]       r_seek_cnt, w_seek_nxt;
  logic             r_synced, w_synced_nxt;
  logic             r_pass, w_pass_nxt;
  logic [7:0]       w_err_inc;

  assign w_err_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_mismatch_nxt = 1'b0;
    w_err_nxt      = r_err_count;
    w_seek_nxt     = r_seek_cnt;
    w_synced_nxt   = r_synced;
    w_pass_nxt     = r_pass;
    // start from any state begins a fresh run; a beat in that cycle is dropped
    if (i_start) begin
      w_state_nxt    = S_SEEK;
      w_expected_nxt = LP_ONE;
      w_err_nxt      = 8'd0;
      w_seek_nxt     = 8'd0;
      w_synced_nxt   = 1'b0;
      w_pass_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_SEEK: begin
          if (i_din_valid) begin
            if (i_din == LP_ONE) begin
              w_state_nxt    = S_CHECK;
              w_expected_nxt = LP_ONE << 1;
              w_synced_nxt   = 1'b1;
            end else begin
              w_seek_nxt = r_seek_cnt + 8'd1;
              if (r_seek_cnt + 8'd1 == LP_SEEK_LIMIT) begin
                w_state_nxt = S_DONE;
                w_pass_nxt  = 1'b0;
              end
            end
          end
        end
        S_CHECK: begin
          if (i_din_valid) begin
            if (i_din != r_expected) begin
              w_mismatch_nxt = 1'b1;
              w_err_nxt      = w_err_inc;
            end
            w_expected_nxt = r_expected << 1;
            // verdict includes the result of this final beat
            if (r_expected == LP_MSB) begin
              w_state_nxt = S_DONE;
              w_pass_nxt  = r_synced && (w_err_nxt == 8'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_expected  <= '0;
      r_mismatch  <= 1'b0;
      r_err_count <= 8'd0;
      r_seek_cnt  <= 8'd0;
      r_synced    <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_mismatch  <= w_mismatch_nxt;
      r_err_count <= w_err_nxt;
      r_seek_cnt  <= w_seek_nxt;
      r_synced    <= w_synced_nxt;
      r_pass      <= w_pass_nxt;
    end
  end

  assign o_expected  = r_expected;
  assign o_mismatch  = r_mismatch;
  assign o_err_count = r_err_count;
  assign o_busy      = (r_state == S_SEEK) || (r_state == S_CHECK);
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = r_pass;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_walk_checker.sv
// Bench for walk_checker: directed and randomized runs compared cycle by cycle
// against a beat-level reference model, plus a wide instance for saturation.
module tb_walk_checker;

  localparam int SL = 16;
  typedef logic [19:0] vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] din;
  logic       valid;
  logic [7:0] o_expected;
  logic       o_mismatch;
  logic [7:0] o_err_count;
  logic       o_busy, o_done, o_pass;
  logic [1:0] o_dbg_state;

  logic         wstart;
  logic [511:0] wdin;
  logic         wvalid;
  logic [511:0] w_expected;
  logic         w_mismatch;
  logic [7:0]   w_err_count;
  logic         w_busy, w_done, w_pass;
  logic [1:0]   w_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] c_din[$];
  bit         c_val[$];
  vec_t       pred_q[$];
  vec_t       obs_q[$];

  walk_checker #(.WIDTH(8), .SEEK_LIMIT(SL)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_din(din), .i_din_valid(valid),
    .o_expected(o_expected), .o_mismatch(o_mismatch), .o_err_count(o_err_count),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_dbg_state(o_dbg_state)
  );

  walk_checker #(.WIDTH(512), .SEEK_LIMIT(SL)) u_wide (
    .i_clk(clk), .i_reset(reset), .i_start(wstart), .i_din(wdin), .i_din_valid(wvalid),
    .o_expected(w_expected), .o_mismatch(w_mismatch), .o_err_count(w_err_count),
    .o_busy(w_busy), .o_done(w_done), .o_pass(w_pass), .o_dbg_state(w_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t sample();
    return {o_mismatch, o_err_count, o_busy, o_done, o_pass, (o_done ? 8'd0 : o_expected)};
  endfunction

  // driver tasks
  task automatic push_cyc(input bit v, input logic [7:0] d);
    c_val.push_back(v);
    c_din.push_back(d);
  endtask

  task automatic clear_stim();
    c_val.delete();
    c_din.delete();
  endtask

  // junk beats, then 1..128 with optional corruption, with gap cycles between beats
  task automatic add_pattern(input int junk, input bit rnd, input int cidx,
                             input logic [7:0] cmask, input int gap_lo, input int gap_hi);
    logic [7:0] v;
    for (int j = 0; j < junk; j++)
      push_cyc(1'b1, rnd ? 8'($urandom_range(0, 255)) : 8'h00);
    for (int b = 0; b < 8; b++) begin
      v = 8'(1 << b);
      if (b == cidx) v = v ^ cmask;
      push_cyc(1'b1, v);
      if (b != 7) begin
        int g;
        g = $urandom_range(gap_lo, gap_hi);
        for (int k = 0; k < g; k++) push_cyc(1'b0, rnd ? 8'($urandom_range(0, 255)) : 8'hFF);
      end
    end
  endtask

  task automatic drive_run(input bit do_start);
    obs_q.delete();
    if (do_start) begin
      start = 1'b1;
      valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      obs_q.push_back(sample());
    end
    for (int i = 0; i < c_din.size(); i++) begin
      valid = c_val[i];
      din   = c_din[i];
      @(posedge clk); #1;
      obs_q.push_back(sample());
    end
    valid = 1'b0;
  endtask

  // reference model: walks the beat list applying the checker's rules
  task automatic model_run(input bit do_start);
    int seen, pos, errs;
    bit sync, fin, mis;
    logic [7:0] e;
    pred_q.delete();
    sync = 0; fin = 0; seen = 0; pos = 0; errs = 0;
    if (do_start) pred_q.push_back({1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1});
    for (int i = 0; i < c_din.size(); i++) begin
      mis = 0;
      if (c_val[i] && !fin) begin
        if (!sync) begin
          if (c_din[i] == 8'd1) begin
            sync = 1; pos = 1;
          end else begin
            seen++;
            if (seen == SL) fin = 1;
          end
        end else begin
          if (int'(c_din[i]) != (1 << pos)) begin
            mis = 1;
            errs = (errs < 255) ? errs + 1 : 255;
          end
          if (pos == 7) fin = 1;
          pos++;
        end
      end
      e = fin ? 8'd0 : 8'(1 << pos);
      pred_q.push_back({mis, 8'(errs), !fin, fin, fin && sync && (errs == 0), e});
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; valid = 1'b0; din = 8'h00;
    wstart = 1'b0; wvalid = 1'b0; wdin = '0;
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if ({o_expected, o_mismatch, o_err_count, o_busy, o_done, o_pass} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {o_expected, o_mismatch, o_err_count, o_busy, o_done, o_pass});
    end
    n_tests++;
    if ({w_mismatch, w_err_count, w_busy, w_done, w_pass} !== 12'd0 || w_expected !== '0) begin
      n_fail++;
      $display("FAIL reset_wide got err=%0d busy=%b want 0", w_err_count, w_busy);
    end
    reset = 1'b0;
    valid = 1'b1; din = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_expected !== 8'd0) begin
        n_fail++;
        $display("FAIL idle_no_start cyc %0d got busy=%b done=%b exp=%h want 0 0 00",
                 i, o_busy, o_done, o_expected);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_clean();
    clear_stim();
    add_pattern(3, 1'b0, -1, 8'h00, 0, 0);
    model_run(1'b1);
    drive_run(1'b1);
    for (int i = 0; i < pred_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== pred_q[i]) begin
        n_fail++;
        $display("FAIL clean cyc %0d got %h want %h", i, obs_q[i], pred_q[i]);
      end
    end
    n_tests++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_err_count !== 8'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_verdict got done=%b pass=%b err=%0d busy=%b want 1 1 0 0",
               o_done, o_pass, o_err_count, o_busy);
    end
  endtask

  task automatic test_corrupt();
    clear_stim();
    add_pattern(3, 1'b0, 4, 8'h01, 0, 0);
    model_run(1'b1);
    drive_run(1'b1);
    for (int i = 0; i < pred_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== pred_q[i]) begin
        n_fail++;
        $display("FAIL corrupt cyc %0d got %h want %h", i, obs_q[i], pred_q[i]);
      end
    end
    n_tests++;
    if (o_done !== 1'b1 || o_pass !== 1'b0 || o_err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL corrupt_verdict got done=%b pass=%b err=%0d want 1 0 1",
               o_done, o_pass, o_err_count);
    end
  endtask

  task automatic test_gapped();
    clear_stim();
    add_pattern(3, 1'b0, -1, 8'h00, 2, 2);
    model_run(1'b1);
    drive_run(1'b1);
    for (int i = 0; i < pred_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== pred_q[i]) begin
        n_fail++;
        $display("FAIL gapped cyc %0d got %h want %h", i, obs_q[i], pred_q[i]);
      end
    end
    n_tests++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL gapped_verdict got done=%b pass=%b err=%0d want 1 1 0",
               o_done, o_pass, o_err_count);
    end
  endtask

  task automatic test_no_sync();
    clear_stim();
    for (int i = 0; i < SL; i++) push_cyc(1'b1, 8'h02);
    push_cyc(1'b1, 8'h01);
    push_cyc(1'b0, 8'h00);
    model_run(1'b1);
    drive_run(1'b1);
    for (int i = 0; i < pred_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== pred_q[i]) begin
        n_fail++;
        $display("FAIL no_sync cyc %0d got %h want %h", i, obs_q[i], pred_q[i]);
      end
    end
    n_tests++;
    if (o_done !== 1'b1 || o_pass !== 1'b0 || o_err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL no_sync_verdict got done=%b pass=%b err=%0d want 1 0 0",
               o_done, o_pass, o_err_count);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      clear_stim();
      add_pattern($urandom_range(0, SL + 2), 1'b1,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1,
                  8'($urandom_range(1, 255)), 0, $urandom_range(0, 2));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) push_cyc(1'b1, 8'($urandom_range(0, 255)));
      model_run(1'b1);
      drive_run(1'b1);
      for (int i = 0; i < pred_q.size(); i++) begin
        n_tests++;
        if (obs_q[i] !== pred_q[i]) begin
          n_fail++;
          $display("FAIL random run %0d cyc %0d got %h want %h", r, i, obs_q[i], pred_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    clear_stim();
    push_cyc(1'b1, 8'h01); push_cyc(1'b1, 8'h02); push_cyc(1'b1, 8'h05); push_cyc(1'b1, 8'h08);
    drive_run(1'b1);
    n_tests++;
    if (o_busy !== 1'b1 || o_err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset got busy=%b err=%0d want 1 1", o_busy, o_err_count);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({o_expected, o_mismatch, o_err_count, o_busy, o_done, o_pass} !== 20'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0",
               {o_expected, o_mismatch, o_err_count, o_busy, o_done, o_pass});
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1; din = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_expected !== 8'd0 || o_err_count !== 8'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc %0d got busy=%b done=%b exp=%h err=%0d want 0 0 00 0",
                 i, o_busy, o_done, o_expected, o_err_count);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_restart();
    clear_stim();
    push_cyc(1'b1, 8'h01); push_cyc(1'b1, 8'h02); push_cyc(1'b1, 8'h03);
    drive_run(1'b1);
    start = 1'b1; valid = 1'b1; din = 8'h01;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0;
    n_tests++;
    if (o_err_count !== 8'd0 || o_expected !== 8'd1 || o_busy !== 1'b1 || o_mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL restart got err=%0d exp=%h busy=%b mis=%b want 0 01 1 0",
               o_err_count, o_expected, o_busy, o_mismatch);
    end
    clear_stim();
    add_pattern(0, 1'b0, -1, 8'h00, 0, 1);
    model_run(1'b0);
    drive_run(1'b0);
    for (int i = 0; i < pred_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== pred_q[i]) begin
        n_fail++;
        $display("FAIL restart_run cyc %0d got %h want %h", i, obs_q[i], pred_q[i]);
      end
    end
    n_tests++;
    if (o_pass !== 1'b1 || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_verdict got done=%b pass=%b want 1 1", o_done, o_pass);
    end
  endtask

  task automatic test_saturation();
    logic [511:0] two;
    two = 512'd2;
    wstart = 1'b1;
    @(posedge clk); #1;
    wstart = 1'b0; wvalid = 1'b1; wdin = 512'd1;
    @(posedge clk); #1;
    n_tests++;
    if (w_expected !== two || w_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_sync got busy=%b exp_low=%h want 1 02", w_busy, w_expected[7:0]);
    end
    wdin = '0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 254 || k == 255 || k == 300) begin
        n_tests++;
        if (w_err_count !== 8'((k < 255) ? k : 255) || w_mismatch !== 1'b1 || w_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL saturate beat %0d got err=%0d mis=%b busy=%b want %0d 1 1",
                   k, w_err_count, w_mismatch, w_busy, (k < 255) ? k : 255);
        end
      end
    end
    wvalid = 1'b0;
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_gapped();
    test_no_sync();
    test_random();
    test_reset_mid_run();
    test_restart();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/walk_checker.md
# walk_checker

Synthesizable response checker for the walking-ones pattern used to exercise the 8-bit register path. It sits on the receive side of a register under test: it samples the register output each clock and synchronises on the first `8'h01` beat. It then verifies each later valid beat as a left shift of the previous one up to the MSB, and reports error count, per-beat mismatch and a final pass/fail verdict. It is the checking end of the stimulus that drives `qin` with 1, 2, 4, … on successive cycles.

## Interface
- `WIDTH`, 8: data width of the checked bus (≥2).
- `SEEK_LIMIT`, 16: maximum valid beats tolerated in SEEK without seeing `1`; range 1–255.
- `clk`  in  1: single clock; all state changes on posedge.
- `reset`  in  1: asynchronous, active-high; forces IDLE and all outputs to reset values immediately.
- `start`  in  1: one-cycle request to begin (or restart) a check run.
- `din`  in  WIDTH: data under check (register `qout`).
- `din_valid`  in  1: `din` is a pattern beat this cycle; beats without it are ignored.
- `expected`  out  WIDTH: value the next valid beat must equal.
- `mismatch`  out  1: one-cycle pulse, the previous valid beat in CHECK differed from `expected`.
- `err_count`  out  8: mismatches in this run, saturating at 255.
- `busy`  out  1: state is SEEK or CHECK.
- `done`  out  1: state is DONE.
- `pass`  out  1: valid only with `done`; run synced, completed and `err_count == 0`.

## Operation
- States: IDLE, SEEK, CHECK, DONE.
- **Reset values:** state IDLE, `expected` 0, `mismatch` 0, `err_count` 0, `busy` 0, `done` 0, `pass` 0.
- **IDLE:**
  - `start` → SEEK.
  - On entry to SEEK: clear `err_count` and the seek counter, set `expected = 1`.
- **SEEK:**
  - Valid beat with `din == 1` → CHECK, `expected <= 2`.
  - Valid beat with any other value increments the seek counter. Such beats never count as errors.
  - When the seek counter reaches `SEEK_LIMIT` → DONE with `pass = 0` (no sync).
- **CHECK:**
  - Each valid beat is compared with `expected`.
  - On inequality: `mismatch` pulses and `err_count` increments, saturating at 255.
  - Every valid beat, match or not, advances `expected <= expected << 1`.
  - The valid beat checked against `1 << (WIDTH-1)` is the last → DONE.
- **DONE:**
  - Holds `done = 1`.
  - `pass = (synced && err_count == 0)`; `pass` is computed including the final beat's result.
  - `expected` holds its last value.
  - `start` → SEEK (new run, counters cleared).
- **`start` while busy:** the run aborts and restarts in SEEK with counters cleared. A beat in that same cycle is ignored.
- **`din_valid` low:** no state, counter or `expected` change in any state.
- **Width rules:**
  - `expected` is a pure WIDTH-bit shift and never wraps within a run.
  - Beats per full run after sync: `WIDTH - 1`.

## Timing
- All outputs are registered. Zero combinational paths from inputs to outputs.
- `busy` rises the cycle after the edge that samples `start`.
- `mismatch` and the `err_count` update appear the cycle after the edge that samples the offending beat. `mismatch` lasts exactly one cycle.
- `done`/`pass` assert the cycle after the edge that samples the last beat (or the `SEEK_LIMIT`-th unsynced beat). That same cycle `busy` falls.
- Back-to-back valid beats every cycle are supported. No throughput limit, no backpressure.
- `reset` asserted mid-run: outputs go to reset values asynchronously. After deassertion the block stays in IDLE until `start`.

## Test plan
- **Clean run:** `start`; beats 8'h00 ×3, then 1, 2, 4, 8, 16, 32, 64, 128 → no `mismatch`, `err_count` 0. `done` and `pass` go to 1 one cycle after the 128 beat.
- **Single corruption:** as the clean run, but 8'h10 replaced by 8'h11 → one `mismatch` pulse the cycle after that beat. Then `err_count` 1, `done` 1, `pass` 0.
- **Gapped valid:** clean pattern with `din_valid` low for 2 cycles between each beat, `din` = 8'hFF during gaps → identical result to the clean run.
- **No sync:** `start`, then 16 valid beats of 8'h02 → DONE after the 16th beat with `pass` 0, `err_count` 0.
- **Saturation:** `WIDTH=8`, `SEEK_LIMIT=16`; repeat corrupted runs, plus a forced build of 300 mismatches via a `WIDTH=512` instance → `err_count` stops at 255.
- **Reset mid-run / restart:**
  - `reset` pulsed after beat 4 → outputs 0 immediately, and the block stays in IDLE until `start`.
  - Separately, `start` reasserted mid-CHECK → `err_count` cleared, `expected` 1, and the following clean pattern passes.
